// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - datapath control bundle between the multicycle MIPS controller and datapath
// InstrCount exists only when MCCTRL_INSTR_COUNT_EN is defined.
interface mips_multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         Opcode;
  logic               Zero;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSrc;
  logic               PCEn;
  logic               Illegal;
  logic [STATE_W-1:0] State;
`ifdef MCCTRL_INSTR_COUNT_EN
  logic [31:0]        InstrCount;
`endif

  // master is the controller, slave is the datapath side
  modport master (
    input  Opcode, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, Illegal, State
`ifdef MCCTRL_INSTR_COUNT_EN
    , output InstrCount
`endif
  );

  modport slave (
    output Opcode, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, Illegal, State
`ifdef MCCTRL_INSTR_COUNT_EN
    , input InstrCount
`endif
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - main control FSM of the multicycle MIPS datapath
// Optional retired-instruction counter enabled by MCCTRL_INSTR_COUNT_EN.
module mips_multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_multicycle_control_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTE  = STATE_W'(6),
    ALUWB    = STATE_W'(7),
    BRANCH   = STATE_W'(8),
    ADDIEX   = STATE_W'(9),
    ADDIWB   = STATE_W'(10),
    JUMP     = STATE_W'(11),
    ILLEGAL  = STATE_W'(12)
  } state_t;

  state_t state;

`ifdef MCCTRL_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
`ifdef MCCTRL_INSTR_COUNT_EN
      instr_count <= '0;
`endif
    end else begin
      case (state)
        FETCH:   state <= DECODE;
        DECODE: begin
          case (bus.Opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXECUTE;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JUMP;
            default:      state <= ILLEGAL;
          endcase
        end
        // a non-memory opcode here means the IR changed underneath us; abandon without writing
        MEMADR: begin
          if (bus.Opcode == OP_LW)      state <= MEMREAD;
          else if (bus.Opcode == OP_SW) state <= MEMWRITE;
          else                          state <= FETCH;
        end
        MEMREAD: state <= MEMWB;
        EXECUTE: state <= ALUWB;
        ADDIEX:  state <= ADDIWB;
        ILLEGAL: state <= ILLEGAL;
        default: state <= FETCH;
      endcase

`ifdef MCCTRL_INSTR_COUNT_EN
      // every terminal state unconditionally retires back to FETCH
      if (state == MEMWB || state == MEMWRITE || state == ALUWB ||
          state == BRANCH || state == ADDIWB || state == JUMP) begin
        instr_count <= instr_count + 32'd1;
      end
`endif
    end
  end

  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, illegal, pcwrite, branch;
  logic [1:0] alusrcb, aluop, pcsrc;

  // gating on reset keeps every enable low while reset is held, not just after the edge
  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    illegal  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    if (!reset) begin
      case (state)
        FETCH: begin
          alusrcb = 2'b01;
          irwrite = 1'b1;
          pcwrite = 1'b1;
        end
        DECODE: alusrcb = 2'b11;
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMREAD: iord = 1'b1;
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        MEMWRITE: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        EXECUTE: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        BRANCH: begin
          alusrca = 1'b1;
          aluop   = 2'b01;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        ADDIWB: regwrite = 1'b1;
        JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.IorD     = iord;
  assign bus.MemWrite = memwrite;
  assign bus.IRWrite  = irwrite;
  assign bus.RegDst   = regdst;
  assign bus.MemtoReg = memtoreg;
  assign bus.RegWrite = regwrite;
  assign bus.ALUSrcA  = alusrca;
  assign bus.ALUSrcB  = alusrcb;
  assign bus.ALUOp    = aluop;
  assign bus.PCSrc    = pcsrc;
  assign bus.PCEn     = pcwrite | (branch & bus.Zero);
  assign bus.Illegal  = illegal;
  assign bus.State    = state;
`ifdef MCCTRL_INSTR_COUNT_EN
  assign bus.InstrCount = instr_count;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - randomized self-checking bench for mips_multicycle_control
// InstrCount checks are active when MCCTRL_INSTR_COUNT_EN is defined.
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_control_if #(.STATE_W(4)) bus ();

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nvec = 0;
  int nerr = 0;
  int unsigned icount = 0;

  localparam logic [5:0] OPS [6] = '{6'b000000, 6'b100011, 6'b101011,
                                     6'b000100, 6'b001000, 6'b000010};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // packed {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,Illegal}
  function automatic logic [13:0] obs_ctrl();
    return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.Illegal};
  endfunction

  // row of the state table from the description, same packing as obs_ctrl
  function automatic logic [13:0] exp_ctrl(input int s);
    case (s)
      0:  return 14'b0_0_1_0_0_0_0_01_00_00_0;
      1:  return 14'b0_0_0_0_0_0_0_11_00_00_0;
      2:  return 14'b0_0_0_0_0_0_1_10_00_00_0;
      3:  return 14'b1_0_0_0_0_0_0_00_00_00_0;
      4:  return 14'b0_0_0_0_1_1_0_00_00_00_0;
      5:  return 14'b1_1_0_0_0_0_0_00_00_00_0;
      6:  return 14'b0_0_0_0_0_0_1_00_10_00_0;
      7:  return 14'b0_0_0_1_0_1_0_00_00_00_0;
      8:  return 14'b0_0_0_0_0_0_1_00_01_01_0;
      9:  return 14'b0_0_0_0_0_0_1_10_00_00_0;
      10: return 14'b0_0_0_0_0_1_0_00_00_00_0;
      11: return 14'b0_0_0_0_0_0_0_00_00_10_0;
      12: return 14'b0_0_0_0_0_0_0_00_00_00_1;
      default: return 14'b0;
    endcase
  endfunction

  task automatic check_cycle(input int s, input string tag);
    logic pcen_exp;
    pcen_exp = (s == 0) || (s == 11) || ((s == 8) && bus.Zero);
    check({tag, "_state"}, 32'(bus.State), 32'(s));
    check({tag, "_ctrl"}, 32'(obs_ctrl()), 32'(exp_ctrl(s)));
    check({tag, "_pcen"}, 32'(bus.PCEn), 32'(pcen_exp));
`ifdef MCCTRL_INSTR_COUNT_EN
    check({tag, "_icount"}, bus.InstrCount, icount);
`endif
  endtask

  // called at a negedge with the DUT in FETCH; returns at the negedge after the instruction
  task automatic run_instr(input logic [5:0] op, input string tag);
    int seq[$];
    bit legal = 1'b1;
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 11};
      default: begin
        legal = 1'b0;
        seq = '{0, 1};
        for (int k = 0; k < 11; k++) seq.push_back(12);
      end
    endcase
    foreach (seq[i]) begin
      bus.Opcode = (seq[i] == 1 || seq[i] == 2) ? op : 6'($urandom);
      bus.Zero   = 1'($urandom);
      #1;
      check_cycle(seq[i], tag);
      @(negedge clk);
    end
    if (legal) icount++;
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_rst_state"}, 32'(bus.State), 32'd0);
    check({tag, "_rst_ctrl"}, 32'(obs_ctrl()), 32'd0);
    check({tag, "_rst_pcen"}, 32'(bus.PCEn), 32'd0);
    icount = 0;
`ifdef MCCTRL_INSTR_COUNT_EN
    check({tag, "_rst_icount"}, bus.InstrCount, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] bad;
    reset      = 1'b1;
    bus.Opcode = 6'b100011;
    bus.Zero   = 1'b1;
    @(negedge clk);
    reset_pulse("init");

    run_instr(6'b100011, "lw");
    run_instr(6'b000000, "rtype");
    bus.Zero = 1'b1;
    run_instr(6'b000100, "beq");
    run_instr(6'b101011, "sw");
    run_instr(6'b000010, "j");

    // directed beq: branch taken and not taken in the BRANCH cycle
    for (int z = 0; z < 2; z++) begin
      bus.Opcode = 6'b000100;
      @(negedge clk);
      @(negedge clk);
      bus.Zero = 1'(z);
      #1;
      check("beq_dir_state", 32'(bus.State), 32'd8);
      check("beq_dir_pcen", 32'(bus.PCEn), 32'(z));
      icount++;
      @(negedge clk);
    end

    // 3 R-type + 1 lw = 17 cycles
    for (int k = 0; k < 3; k++) run_instr(6'b000000, "rt3");
    run_instr(6'b100011, "lw17");

    for (int n = 0; n < 40; n++) run_instr(OPS[$urandom_range(0, 5)], "rand");

    // reset during MEMREAD of a lw must not let any write through
    bus.Opcode = 6'b100011;
    for (int k = 0; k < 3; k++) @(negedge clk);
    #1;
    check("mid_state", 32'(bus.State), 32'd3);
    reset = 1'b1;
    #1;
    check("mid_rst_we", 32'({bus.MemWrite, bus.RegWrite}), 32'd0);
    reset_pulse("mid");
    run_instr(6'b000000, "post_mid");

    // illegal opcode halts until reset
    do bad = 6'($urandom); while (bad inside {6'b000000, 6'b100011, 6'b101011,
                                              6'b000100, 6'b001000, 6'b000010});
    run_instr(bad, "illegal");
    reset_pulse("ill");
    run_instr(6'b001000, "addi");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles from the 6-bit opcode.
- Generates all datapath enables and selects, including the 2-bit ALUOp consumed by the ALU decoder.
- ALUOp encoding is fixed: 00 = add, 01 = subtract, 10 = decode from Funct.

Parameters:
- STATE_W, 4, width of the state register and of the debug State port.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces FETCH
- Opcode  input  6  instr[31:26] from the instruction register
- Zero  input  1  ALU zero flag, used in BRANCH
- IorD  output  1  memory address select, 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register load
- RegDst  output  1  write register select, 0 = rt, 1 = rd
- MemtoReg  output  1  writeback data select, 0 = ALUOut, 1 = Data
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select, 0 = PC, 1 = A
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUOp  output  2  to the ALU decoder
- PCSrc  output  2  PC next select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  output  1  PC load = PCWrite | (Branch & Zero)
- Illegal  output  1  sticky illegal-opcode flag
- State  output  STATE_W  current state, for debug

Behaviour:
- Single clock domain.
- reset is asynchronous, active-high. Asserting it forces state to FETCH immediately.
- While reset is high, every output is 0 and State = FETCH encoding 0.
- Outputs are Moore: a combinational decode of the state, except PCEn, which also uses Zero.
- Any output not listed for a state is 0.
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- States, encodings, outputs and transitions:
  - FETCH (0): IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1. Next: DECODE.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Next, by Opcode:
    - lw or sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - anything else -> ILLEGAL
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD (3): IorD=1. Next: MEMWB.
  - MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWRITE (5): IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - ALUWB (7): RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next: FETCH.
  - ADDIEX (9): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
  - ADDIWB (10): RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - JUMP (11): PCSrc=10, PCWrite=1. Next: FETCH.
  - ILLEGAL (12): all enables 0, Illegal=1. Remains in ILLEGAL until reset (the CPU halts).
  - Unused encodings 13-15: next state FETCH, outputs 0.
- Instruction latency in cycles, FETCH to return to FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Opcode is sampled only in DECODE and MEMADR; changes in any other state are ignored.
- PCEn = PCWrite | (Branch & Zero), evaluated combinationally in the same cycle.
- Reset asserted mid-instruction: the write enables drop asynchronously and the state returns to FETCH. No partial write completes after reset assertion.

Optional Feature:
- Macro: MCCTRL_INSTR_COUNT_EN.
- When defined:
  - Adds output InstrCount, 32 bits.
  - InstrCount is cleared by reset.
  - It increments by 1 on each clock edge where the state leaves a terminal state (MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP) for FETCH.
  - It wraps from 0xFFFFFFFF to 0.
  - It holds in ILLEGAL.
- When not defined:
  - No InstrCount port and no counter logic.
  - FSM behaviour is identical in both builds.

Test Plan:
- Reset with Opcode=100011 held -> all outputs 0 during reset. After release, the State sequence is 0,1,2,3,4,0. MemWB cycle shows RegWrite=1 and MemtoReg=1.
- R-type, Opcode=000000 -> State sequence 0,1,6,7,0. ALUOp=10 in EXECUTE; RegDst=1 and RegWrite=1 in ALUWB.
- beq, Opcode=000100, Zero=1 in BRANCH -> PCEn=1, PCSrc=01, ALUOp=01. Repeat with Zero=0 -> PCEn=0.
- sw then j -> sw: 0,1,2,5,0 with MemWrite=1 and IorD=1 in state 5. j: 0,1,11,0 with PCSrc=10 and PCEn=1.
- Opcode=111111 -> DECODE goes to ILLEGAL (12) and Illegal=1. It stays for 10 cycles with all enables 0. Assert reset -> State=0 and Illegal=0.
- With MCCTRL_INSTR_COUNT_EN defined, run 3 R-type + 1 lw -> InstrCount=4 after 17 cycles. Assert reset in MEMREAD of the lw -> InstrCount=0 and MemWrite/RegWrite never asserted.
